l1_data_ldst_queue: RTL

L1_DATA_LDST_QUEUE -- requirements
Module: l1_data_ldst_queue

---
 rtl/l1_data_ldst_queue.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/l1_data_ldst_queue.sv
// -----------------------------------------------------------------------------
// l1_data_ldst_queue
//
// Purpose: buffers load/store requests from the execute stage in a small FIFO
// and issues them one at a time to the L1 data cache. Each request gets exactly
// one registered completion pulse back to the execute stage, unless a flush
// (iREMOVE) or reset removes it first. Misaligned heads never reach the cache.
// They are popped and completed with an alignment fault.
//
// Ports:
//   iCLOCK, inRESET      clock (rising edge), asynchronous active-low reset
//   iREMOVE              one-cycle flush of the queue and any pending response
//   iEXE_*  / oEXE_BUSY  request push side (accepted on iEXE_REQ && !oEXE_BUSY)
//   oEXE_VALID ...       one-cycle completion: fault bits, MMU flags, load data
//   oLDST_* / iLDST_BUSY request to the cache, head entry of the queue
//   iLDST_VALID ...      cache completion (page fault, flags, read word)
//
// Handshakes: a push happens on the clock edge where iEXE_REQ=1 and
// oEXE_BUSY=0. A cache request transfers on the edge where oLDST_REQ=1 and
// iLDST_BUSY=0, and the head entry is popped on that same edge. oLDST_REQ does
// not depend on iLDST_BUSY. The cache answers with a single iLDST_VALID cycle,
// and only one cache request is ever outstanding.
// -----------------------------------------------------------------------------
module l1_data_ldst_queue #(
  parameter int P_DEPTH = 4
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iREMOVE,
  input  logic        iEXE_REQ,
  output logic        oEXE_BUSY,
  input  logic [1:0]  iEXE_ORDER,
  input  logic        iEXE_RW,
  input  logic [65:0] iEXE_CTX,
  input  logic [31:0] iEXE_ADDR,
  input  logic [31:0] iEXE_DATA,
  output logic        oEXE_VALID,
  output logic        oEXE_PAGEFAULT,
  output logic        oEXE_ALIGN_FAULT,
  output logic [13:0] oEXE_MMU_FLAGS,
  output logic [31:0] oEXE_DATA,
  output logic        oLDST_REQ,
  input  logic        iLDST_BUSY,
  output logic [1:0]  oLDST_ORDER,
  output logic [3:0]  oLDST_MASK,
  output logic        oLDST_RW,
  output logic [65:0] oLDST_CTX,
  output logic [31:0] oLDST_ADDR,
  output logic [31:0] oLDST_DATA,
  input  logic        iLDST_VALID,
  input  logic        iLDST_PAGEFAULT,
  input  logic [13:0] iLDST_MMU_FLAGS,
  input  logic [31:0] iLDST_DATA
);

  localparam int PW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(P_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]  order;
    logic        rw;
    logic [65:0] ctx;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  state_t        state, state_nx;
  entry_t        q_mem [P_DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic          push, pop, ldst_req, align_fault_nx, cpl_fire;
  logic          head_misaligned;
  logic [3:0]    head_mask;
  logic [31:0]   head_wdata;
  logic [31:0]   load_data;

  // Attributes of the entry currently outstanding at the cache; the response
  // word is sliced with these after the entry has already left the queue.
  logic [1:0]    iss_order;
  logic [1:0]    iss_lo;
  logic          iss_rw;
  // Set when a flush hits while a cache response is still owed, so that
  // response is swallowed instead of completing a flushed request.
  logic          discard;

  assign head      = q_mem[rd_ptr];
  assign oEXE_BUSY = (count == FULL_COUNT);
  // A flush in the push cycle drops the push as well.
  assign push      = iEXE_REQ && !oEXE_BUSY && !iREMOVE;

  assign head_misaligned = ((head.order == 2'd1) && head.addr[0]) ||
                           (head.order[1] && (head.addr[1:0] != 2'b00));

  always_comb begin
    case (head.order)
      2'd0:    head_mask = 4'b0001 << head.addr[1:0];
      2'd1:    head_mask = head.addr[1] ? 4'b1100 : 4'b0011;
      default: head_mask = 4'b1111;
    endcase
  end

  always_comb begin
    case (head.order)
      2'd0:    head_wdata = {4{head.data[7:0]}};
      2'd1:    head_wdata = {2{head.data[15:0]}};
      default: head_wdata = head.data;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Issue FSM: next state and per-cycle controls
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx       = state;
    pop            = 1'b0;
    ldst_req       = 1'b0;
    align_fault_nx = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((count != '0) && !iREMOVE) state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (iREMOVE) begin
          state_nx = ST_IDLE;
        end else if (head_misaligned) begin
          pop            = 1'b1;
          align_fault_nx = 1'b1;
          state_nx       = ST_IDLE;
        end else begin
          ldst_req = 1'b1;
          if (!iLDST_BUSY) begin
            pop      = 1'b1;
            state_nx = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (iLDST_VALID) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign cpl_fire = (state == ST_WAIT) && iLDST_VALID && !discard && !iREMOVE;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // ---------------------------------------------------------------------------
  // Queue storage and pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLOCK) begin
    if (push) q_mem[wr_ptr] <= '{order: iEXE_ORDER, rw: iEXE_RW, ctx: iEXE_CTX,
                                 addr: iEXE_ADDR, data: iEXE_DATA};
  end

  // Pointers wrap naturally because P_DEPTH is a power of two.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (iREMOVE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding-request bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      iss_order <= 2'd0;
      iss_lo    <= 2'd0;
      iss_rw    <= 1'b0;
      discard   <= 1'b0;
    end else begin
      if (ldst_req && !iLDST_BUSY) begin
        iss_order <= head.order;
        iss_lo    <= head.addr[1:0];
        iss_rw    <= head.rw;
      end
      if (state == ST_WAIT) discard <= iLDST_VALID ? 1'b0 : (discard | iREMOVE);
      else                  discard <= 1'b0;
    end
  end

  always_comb begin
    load_data = 32'h0;
    if (iss_rw) begin
      case (iss_order)
        2'd0: begin
          case (iss_lo)
            2'd0:    load_data = {24'h0, iLDST_DATA[7:0]};
            2'd1:    load_data = {24'h0, iLDST_DATA[15:8]};
            2'd2:    load_data = {24'h0, iLDST_DATA[23:16]};
            default: load_data = {24'h0, iLDST_DATA[31:24]};
          endcase
        end
        2'd1:    load_data = iss_lo[1] ? {16'h0, iLDST_DATA[31:16]} : {16'h0, iLDST_DATA[15:0]};
        default: load_data = iLDST_DATA;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered completion towards the execute stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      oEXE_VALID       <= 1'b0;
      oEXE_PAGEFAULT   <= 1'b0;
      oEXE_ALIGN_FAULT <= 1'b0;
      oEXE_MMU_FLAGS   <= 14'h0;
      oEXE_DATA        <= 32'h0;
    end else begin
      oEXE_VALID       <= cpl_fire | align_fault_nx;
      oEXE_PAGEFAULT   <= cpl_fire & iLDST_PAGEFAULT;
      oEXE_ALIGN_FAULT <= align_fault_nx;
      oEXE_MMU_FLAGS   <= cpl_fire ? iLDST_MMU_FLAGS : 14'h0;
      oEXE_DATA        <= cpl_fire ? load_data : 32'h0;
    end
  end

  // Cache-side fields are zero unless a request is presented, which also
  // keeps them zero while reset holds the queue empty.
  always_comb begin
    oLDST_REQ   = ldst_req;
    oLDST_ORDER = 2'd0;
    oLDST_MASK  = 4'h0;
    oLDST_RW    = 1'b0;
    oLDST_CTX   = 66'h0;
    oLDST_ADDR  = 32'h0;
    oLDST_DATA  = 32'h0;
    if (ldst_req) begin
      oLDST_ORDER = head.order;
      oLDST_MASK  = head_mask;
      oLDST_RW    = head.rw;
      oLDST_CTX   = head.ctx;
      oLDST_ADDR  = head.addr;
      oLDST_DATA  = head_wdata;
    end
  end

endmodule
